// File: rtl/armleo_axi_native_master_pkg.sv
// Shared definitions for armleo_axi_native_master: AXI burst/response
// constants, the bridge FSM state encoding and a response-merge helper.
package armleo_axi_native_master_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t STATE_IDLE      = 3'd0;
    localparam state_t STATE_WRITE     = 3'd1;
    localparam state_t STATE_WRESP     = 3'd2;
    localparam state_t STATE_READ_ADDR = 3'd3;
    localparam state_t STATE_READ_DATA = 3'd4;
    localparam state_t STATE_RESPOND   = 3'd5;

    // A wrong ID or a missing last beat is a protocol fault of the slave;
    // report it as SLVERR regardless of what the slave claimed.
    function automatic logic [1:0] axi_resp_merge(
        input logic [1:0] resp,
        input logic       id_ok,
        input logic       last_ok
    );
        return (id_ok && last_ok) ? resp : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/armleo_axi_native_master.sv
// Native request/response bus to AXI4 master bridge, one transaction in
// flight. Each command becomes a single-beat write (AW+W -> B) or read
// (AR -> R); the result is held on rsp_* until rsp_ready.
// Optional feature: ARMLEO_AXI_NATIVE_MASTER_ALIGN_CHECK_EN rejects
// commands whose address is not aligned to the data width with SLVERR
// and issues no AXI transaction.
module armleo_axi_native_master
    import armleo_axi_native_master_pkg::*;
#(
    parameter int                  ADDR_WIDTH      = 32,
    parameter int                  ID_WIDTH        = 4,
    parameter int                  DATA_WIDTH_ENUM = 5,
    parameter logic [ID_WIDTH-1:0] AXI_ID          = '0,
    localparam int                 DATA_WIDTH      = 1 << DATA_WIDTH_ENUM,
    localparam int                 STRB_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Native command/response side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    // AXI4 write address
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [ID_WIDTH-1:0]   awid,

    // AXI4 write data
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wlast,

    // AXI4 write response
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    input  logic [ID_WIDTH-1:0]   bid,

    // AXI4 read address
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_WIDTH-1:0]   arid,

    // AXI4 read data
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic [ID_WIDTH-1:0]   rid
);

    localparam logic [2:0] AXI_SIZE = 3'(DATA_WIDTH_ENUM - 3);

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    logic                  cmd_accept;
    logic                  misaligned;
    logic                  aw_done;
    logic                  w_done;

`ifdef ARMLEO_AXI_NATIVE_MASTER_ALIGN_CHECK_EN
    localparam int              ADDR_LSB   = DATA_WIDTH_ENUM - 3;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
    assign misaligned = |(cmd_addr & ALIGN_MASK);
`else
    assign misaligned = 1'b0;
`endif

    // Ready outputs are pure decodes of the state.
    assign cmd_ready  = (state == STATE_IDLE);
    assign bready     = (state == STATE_WRESP);
    assign rready     = (state == STATE_READ_DATA);
    assign cmd_accept = cmd_valid && cmd_ready;

    // A channel counts as done once its valid is gone or handshakes now;
    // AW and W may complete in any order or together.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    // Captured command drives both address channels and the W payload.
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

    // Single-beat INCR transfers with the fixed ID.
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = AXI_SIZE;
    assign arsize  = AXI_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign awid    = AXI_ID;
    assign arid    = AXI_ID;
    assign wlast   = 1'b1;

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: begin
                if (cmd_valid) begin
                    if (misaligned)     state_next = STATE_RESPOND;
                    else if (cmd_write) state_next = STATE_WRITE;
                    else                state_next = STATE_READ_ADDR;
                end
            end
            STATE_WRITE:     if (aw_done && w_done) state_next = STATE_WRESP;
            STATE_WRESP:     if (bvalid)            state_next = STATE_RESPOND;
            STATE_READ_ADDR: if (arready)           state_next = STATE_READ_DATA;
            STATE_READ_DATA: if (rvalid)            state_next = STATE_RESPOND;
            STATE_RESPOND:   if (rsp_ready)         state_next = STATE_IDLE;
            default:                                state_next = STATE_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= STATE_IDLE;
        else        state <= state_next;
    end

    // Capture the command payload when it is accepted; held for the
    // whole transaction so AXI outputs stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // AXI request valids: raised on accept, each dropped by its own ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            arvalid <= 1'b0;
        end else begin
            if (cmd_accept && !misaligned && cmd_write) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end else begin
                if (awvalid && awready) awvalid <= 1'b0;
                if (wvalid && wready)   wvalid  <= 1'b0;
            end

            if (cmd_accept && !misaligned && !cmd_write)
                arvalid <= 1'b1;
            else if (arvalid && arready)
                arvalid <= 1'b0;
        end
    end

    // Response register: loaded from B, R or the alignment check and held
    // until the native side takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (cmd_valid && misaligned) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= AXI_RESP_SLVERR;
                    end
                end
                STATE_WRESP: begin
                    if (bvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= axi_resp_merge(bresp, bid == AXI_ID, 1'b1);
                    end
                end
                STATE_READ_DATA: begin
                    if (rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_resp  <= axi_resp_merge(rresp, rid == AXI_ID, rlast);
                    end
                end
                STATE_RESPOND: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_armleo_axi_native_master.sv
// Self-checking bench for armleo_axi_native_master: a 1024-word AXI BRAM
// slave with per-channel ready delays and fault knobs, an expected-response
// queue computed from a reference memory, and one compare process.
module tb_armleo_axi_native_master;

    localparam logic [3:0] AXI_ID = 4'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    armleo_axi_native_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] rdata; logic [1:0] resp; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:1023];
    bit          id_err = 0, last_err = 0;

    function automatic void predict(input bit wr, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   in_range = (a < 32'h1000);
        int   idx = int'(a[11:2]);
        e.rdata = '0;
        e.resp  = in_range ? 2'b00 : 2'b11;
`ifdef ARMLEO_AXI_NATIVE_MASTER_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            e.resp = 2'b10;
            exp_q.push_back(e);
            return;
        end
`endif
        if (wr) begin
            if (in_range)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            if (id_err) e.resp = 2'b10;
        end else begin
            if (in_range) e.rdata = ref_mem[idx];
            if (id_err || last_err) e.resp = 2'b10;
        end
        exp_q.push_back(e);
    endfunction

    // ---------------- AXI BRAM slave ----------------
    logic [31:0] smem [0:1023];
    int  aw_delay = 0, w_delay = 0, ar_delay = 0;
    int  aw_cnt, w_cnt, ar_cnt;
    int  aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cyc = 0;
    bit  aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_a, w_d, r_a;
    logic [3:0]  w_s;
    logic [1:0]  b_r;

    // Slave decides its outputs at negedge for the following posedge.
    initial begin
        for (int i = 0; i < 1024; i++) begin smem[i] = '0; ref_mem[i] = '0; end
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                continue;
            end
            bvalid = b_pend; bresp = b_r; bid = AXI_ID + 4'(id_err);
            if (bvalid && bready) begin b_pend = 0; b_hs_cyc = cyc; end
            rvalid = r_pend; rid = AXI_ID + 4'(id_err); rlast = !last_err;
            rdata  = (r_a < 32'h1000) ? smem[r_a[11:2]] : 32'h0;
            rresp  = (r_a < 32'h1000) ? 2'b00 : 2'b11;
            if (rvalid && rready) r_pend = 0;

            awready = awvalid && (aw_cnt >= aw_delay);
            if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; aw_hs_cnt++; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            wready = wvalid && (w_cnt >= w_delay);
            if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; w_hs_cnt++; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1;
                b_r = (aw_a < 32'h1000) ? 2'b00 : 2'b11;
                if (aw_a < 32'h1000)
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) smem[aw_a[11:2]][8*b +: 8] = w_d[8*b +: 8];
            end

            arready = arvalid && (ar_cnt >= ar_delay);
            if (arvalid && arready) begin r_pend = 1; r_a = araddr; ar_hs_cnt++; ar_cnt = 0; end
            else if (arvalid) ar_cnt++;
        end
    end

    // ---------------- compare process ----------------
    int  aw_rise_cyc, ar_rise_cyc, rsp_rise_cyc, ar_cyc_cnt = 0;
    logic [31:0] ar_rise_addr, prev_awaddr, prev_rdata;
    logic [1:0]  prev_resp;
    bit  prev_aw, prev_ar, prev_rsp, aw_hold, rsp_hold;

    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            prev_aw = 0; prev_ar = 0; prev_rsp = 0; aw_hold = 0; rsp_hold = 0;
            continue;
        end
        if (awvalid && !prev_aw) aw_rise_cyc = cyc;
        if (arvalid && !prev_ar) begin ar_rise_cyc = cyc; ar_rise_addr = araddr; end
        if (rsp_valid && !prev_rsp) rsp_rise_cyc = cyc;
        if (arvalid) ar_cyc_cnt++;
        if (aw_hold) begin
            chk("aw_hold_valid", 64'(awvalid), 1);
            chk("aw_hold_addr", 64'(awaddr), 64'(prev_awaddr));
        end
        if (rsp_hold) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 1);
            chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(prev_rdata));
            chk("rsp_hold_resp", 64'(rsp_resp), 64'(prev_resp));
        end
        if (awvalid) begin
            chk("awlen", 64'(awlen), 0); chk("awsize", 64'(awsize), 2);
            chk("awburst", 64'(awburst), 1); chk("awid", 64'(awid), 64'(AXI_ID));
        end
        if (wvalid) chk("wlast", 64'(wlast), 1);
        if (arvalid) begin
            chk("arlen", 64'(arlen), 0); chk("arsize", 64'(arsize), 2);
            chk("arburst", 64'(arburst), 1); chk("arid", 64'(arid), 64'(AXI_ID));
        end
        if (rsp_valid) begin
            chk("rsp_cmd_ready", 64'(cmd_ready), 0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                chk("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
        prev_aw = awvalid; prev_ar = arvalid; prev_rsp = rsp_valid;
        aw_hold = awvalid && !awready; prev_awaddr = awaddr;
        rsp_hold = rsp_valid && !rsp_ready; prev_rdata = rsp_rdata; prev_resp = rsp_resp;
    end

    // ---------------- stimulus ----------------
    int c0;

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #2; endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        predict(wr, a, d, s);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        c0 = cyc;
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        chk("rsp_drain", 64'(exp_q.size()), 0);
        tick();
    endtask

    task automatic wait_rsp();
        int n = 0;
        mid();
        while (!rsp_valid && n < 200) begin mid(); n++; end
        chk("rsp_seen", 64'(rsp_valid), 1);
    endtask

    int a0, w0;

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 1;
        tick(); tick(); mid();
        chk("rst_awvalid", 64'(awvalid), 0); chk("rst_wvalid", 64'(wvalid), 0);
        chk("rst_arvalid", 64'(arvalid), 0); chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 0); chk("rst_rsp_resp", 64'(rsp_resp), 0);
        chk("rst_cmd_ready", 64'(cmd_ready), 1); chk("rst_bready", 64'(bready), 0);
        chk("rst_rready", 64'(rready), 0);
        tick(); rst_n = 1; tick();

        // T1: write 0x10, minimum latency
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF);
        mid();
        chk("t1_awvalid_c1", 64'(awvalid), 1); chk("t1_wvalid_c1", 64'(wvalid), 1);
        chk("t1_awaddr", 64'(awaddr), 64'h10); chk("t1_wdata", 64'(wdata), 64'hDEADBEEF);
        chk("t1_wstrb", 64'(wstrb), 64'hF);
        tick(); mid();
        chk("t1_bready_c2", 64'(bready), 1); chk("t1_bvalid_c2", 64'(bvalid), 1);
        tick(); mid();
        chk("t1_rsp_valid_c3", 64'(rsp_valid), 1); chk("t1_rsp_resp", 64'(rsp_resp), 0);
        chk("t1_rsp_rdata", 64'(rsp_rdata), 0);
        wait_done();
        chk("t1_aw_lat", 64'(aw_rise_cyc - c0), 1);
        chk("t1_b_lat", 64'(b_hs_cyc - c0), 2);
        chk("t1_rsp_lat", 64'(rsp_rise_cyc - c0), 3);

        // T2: read back 0x10
        issue(0, 32'h10, 32'h0, 4'h0);
        wait_rsp();
        chk("t2_rdata", 64'(rsp_rdata), 64'hDEADBEEF); chk("t2_resp", 64'(rsp_resp), 0);
        chk("t2_araddr", 64'(ar_rise_addr), 64'h10);
        chk("t2_rsp_lat", 64'(rsp_rise_cyc - c0), 3);
        wait_done();

        // T3: AW 3 cycles after W, then W 3 cycles after AW
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 3 : 0;
            w_delay  = (k == 0) ? 0 : 3;
            a0 = aw_hs_cnt; w0 = w_hs_cnt;
            issue(1, 32'h40 + 32'(4*k), 32'h12345678 + 32'(k), 4'hF);
            wait_done();
            chk("t3_aw_hs", 64'(aw_hs_cnt - a0), 1);
            chk("t3_w_hs", 64'(w_hs_cnt - w0), 1);
            chk("t3_b_cyc", 64'(b_hs_cyc - c0), 5);
            chk("t3_rsp_after_b", 64'(rsp_rise_cyc - b_hs_cyc), 1);
        end
        aw_delay = 0; w_delay = 0;
        issue(0, 32'h44, 32'h0, 4'h0);
        wait_rsp(); chk("t3_readback", 64'(rsp_rdata), 64'h12345679);
        wait_done();

        // Partial strobes merge into the existing word
        issue(1, 32'h20, 32'h11223344, 4'hF); wait_done();
        issue(1, 32'h20, 32'hAABBCCDD, 4'h5); wait_done();
        issue(0, 32'h20, 32'h0, 4'h0);
        wait_rsp(); chk("strb_merge", 64'(rsp_rdata), 64'h11BB33DD);
        wait_done();

        // T4: out-of-range read -> DECERR, response held under backpressure
        rsp_ready = 0;
        issue(0, 32'h1000_0000, 32'h0, 4'h0);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            chk("t4_decerr", 64'(rsp_resp), 64'h3);
            chk("t4_cmd_ready", 64'(cmd_ready), 0);
            tick(); mid();
        end
        tick(); rsp_ready = 1;
        wait_done();

        // T5: wrong rid, missing rlast, wrong bid -> SLVERR
        id_err = 1;
        issue(0, 32'h10, 32'h0, 4'h0);
        wait_rsp(); chk("t5_rid_slverr", 64'(rsp_resp), 64'h2);
        wait_done();
        issue(1, 32'h50, 32'h55AA55AA, 4'hF);
        wait_rsp(); chk("t5_bid_slverr", 64'(rsp_resp), 64'h2);
        wait_done();
        id_err = 0; last_err = 1;
        issue(0, 32'h10, 32'h0, 4'h0);
        wait_rsp(); chk("t5_rlast_slverr", 64'(rsp_resp), 64'h2);
        wait_done();
        last_err = 0;

        // Unaligned address: rejected with the align check, passed through otherwise
        a0 = ar_cyc_cnt;
        issue(0, 32'h12, 32'h0, 4'h0);
        wait_rsp();
`ifdef ARMLEO_AXI_NATIVE_MASTER_ALIGN_CHECK_EN
        chk("align_slverr", 64'(rsp_resp), 64'h2);
        chk("align_rdata", 64'(rsp_rdata), 0);
        wait_done();
        chk("align_no_ar", 64'(ar_cyc_cnt - a0), 0);
`else
        chk("unaligned_araddr", 64'(ar_rise_addr), 64'h12);
        chk("unaligned_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        wait_done();
        chk("unaligned_ar_cycles", 64'(ar_cyc_cnt - a0), 1);
`endif

        // T6: reset while AW is pending, then normal operation
        aw_delay = 10;
        issue(1, 32'h2000_0000, 32'h0, 4'hF);
        tick();
        chk("t6_aw_pending", 64'(awvalid), 1);
        rst_n = 0; tick();
        rst_n = 1; exp_q.delete(); aw_delay = 0;
        chk("t6_awvalid", 64'(awvalid), 0); chk("t6_wvalid", 64'(wvalid), 0);
        chk("t6_arvalid", 64'(arvalid), 0); chk("t6_rsp_valid", 64'(rsp_valid), 0);
        chk("t6_idle", 64'(cmd_ready), 1);
        tick();
        issue(1, 32'h30, 32'hCAFEF00D, 4'hF); wait_done();
        issue(0, 32'h30, 32'h0, 4'h0);
        wait_rsp(); chk("t6_readback", 64'(rsp_rdata), 64'hCAFEF00D);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
